// File: rtl/warmboot_ctrl.sv
// Warm-boot controller: qualifies fabric reboot requests, drives the bitstream
// loader handshake, and falls back to the golden slot once on a failed load.
module warmboot_ctrl #(
  parameter logic [23:0] SLOT_BASE      = 24'h000000,
  parameter int unsigned SLOT_SHIFT     = 18,
  parameter int unsigned BOOT_HOLD      = 4,
  parameter int unsigned RST_CYCLES     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 2**20,
  parameter int unsigned POR_BOOT       = 1
) (
  input  logic        UserCLK,
  input  logic        RESET,
  input  logic        BOOT_top,
  input  logic [3:0]  SLOT_top,
  output logic        CONFIGURED_top,
  output logic        RESET_top,
  output logic        LOAD_REQ,
  output logic [23:0] LOAD_ADDR,
  input  logic        LOAD_ACK,
  input  logic        LOAD_DONE,
  input  logic        LOAD_ERR,
  output logic [3:0]  ACTIVE_SLOT,
  output logic        FAILED
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned CW = (TW > 8) ? TW : 8;

  typedef enum logic [2:0] {
    S_IDLE, S_QUAL, S_REQ, S_LOAD, S_RST, S_FAIL
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [3:0]      slot_nxt;
  logic            armed, armed_nxt;
  logic            por;
  logic            load_fail;
  logic            boot_q1, boot_s;
  logic [3:0]      slot_q1, slot_s;

  function automatic logic [23:0] slot_addr(input logic [3:0] s);
    return SLOT_BASE + (24'(s) << SLOT_SHIFT);
  endfunction

  // Two-flop synchronizers for the asynchronous fabric request inputs
  always_ff @(posedge UserCLK) begin
    if (RESET) begin
      boot_q1 <= 1'b0;
      boot_s  <= 1'b0;
      slot_q1 <= '0;
      slot_s  <= '0;
    end else begin
      boot_q1 <= BOOT_top;
      boot_s  <= boot_q1;
      slot_q1 <= SLOT_top;
      slot_s  <= slot_q1;
    end
  end

  // State, shared counter, slot/address and arming registers
  always_ff @(posedge UserCLK) begin
    if (RESET) begin
      state       <= S_IDLE;
      por         <= 1'b1;
      cnt         <= '0;
      armed       <= 1'b0;
      ACTIVE_SLOT <= '0;
      LOAD_ADDR   <= '0;
    end else begin
      state       <= state_nxt;
      por         <= 1'b0;
      cnt         <= cnt_nxt;
      armed       <= armed_nxt;
      ACTIVE_SLOT <= slot_nxt;
      LOAD_ADDR   <= slot_addr(slot_nxt);
    end
  end

  // Next-state logic and Moore outputs; por marks the first cycle after reset
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    slot_nxt       = ACTIVE_SLOT;
    armed_nxt      = armed;
    load_fail      = 1'b0;
    CONFIGURED_top = 1'b0;
    RESET_top      = 1'b1;
    LOAD_REQ       = 1'b0;
    FAILED         = 1'b0;
    if (por) begin
      state_nxt = (POR_BOOT != 0) ? S_REQ : S_IDLE;
      cnt_nxt   = '0;
      slot_nxt  = '0;
    end else begin
      case (state)
        S_IDLE: begin
          CONFIGURED_top = 1'b1;
          RESET_top      = 1'b0;
          if (!boot_s) begin
            armed_nxt = 1'b1;
          end else if (armed) begin
            state_nxt = S_QUAL;
            cnt_nxt   = CW'(1);
          end
        end
        S_QUAL: begin
          CONFIGURED_top = 1'b1;
          RESET_top      = 1'b0;
          if (!boot_s) begin
            state_nxt = S_IDLE;
          end else if (cnt >= CW'(BOOT_HOLD)) begin
            slot_nxt  = slot_s;
            state_nxt = S_REQ;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        S_REQ: begin
          LOAD_REQ = 1'b1;
          if (LOAD_ACK) begin
            state_nxt = S_LOAD;
            cnt_nxt   = '0;
          end
        end
        S_LOAD: begin
          // ERR wins over a simultaneous DONE; DONE wins over the timeout edge
          if (LOAD_ERR) begin
            load_fail = 1'b1;
          end else if (LOAD_DONE) begin
            state_nxt = S_RST;
            cnt_nxt   = '0;
          end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            load_fail = 1'b1;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
          if (load_fail) begin
            if (ACTIVE_SLOT != 4'd0) begin
              slot_nxt  = '0;
              state_nxt = S_REQ;
            end else begin
              state_nxt = S_FAIL;
            end
          end
        end
        S_RST: begin
          CONFIGURED_top = 1'b1;
          if (cnt == CW'(RST_CYCLES - 1)) begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        S_FAIL: begin
          FAILED = 1'b1;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
    if (state_nxt == S_REQ) armed_nxt = 1'b0;
  end

endmodule
